exu_wb_pipereg: RTL and testbench

Parametrised, multi-channel writeback pipeline register placed between execution-unit outputs (integer, memory, future FP/branch units) and the writeback/ROB-complete stage inside `exu_top`. Each channel is an independent DEPTH-entry FIFO with valid/ready backpressure. Each entry carries a robid plus an opaque payload. Entries younger than a flushing robid are squashed in place, so units can retire results without stalling on a slow writeback port.

---
 rtl/exu_wb_pkg.sv | 29 ++
 rtl/exu_wb_chan_fifo.sv | 121 ++++++++++++
 rtl/exu_wb_pipereg.sv | 62 ++++++
 tb/tb_exu_wb_pipereg.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_wb_pkg.sv
// ---------------------------------------------------------------------------
// exu_wb_pkg
// Shared definitions for the execution-unit writeback pipeline register.
//   ROBID_W_DEF   : default robid width (instantiators override via ROBID_W)
//   robid_younger : wrap-aware age compare used by every flush in the backend
// ---------------------------------------------------------------------------
package exu_wb_pkg;

   localparam int ROBID_W_DEF = 6;

   // Robids of up to 32 bits are compared; callers zero-extend into the
   // 32-bit arguments and pass their real width in w.
   localparam int ROBID_W_MAX = 32;

   // True when robid a is strictly younger than robid b. The MSB is a wrap
   // bit: differing wrap bits invert the sense of the low-bit comparison.
   function automatic logic robid_younger(input logic [ROBID_W_MAX-1:0] a,
                                          input logic [ROBID_W_MAX-1:0] b,
                                          input int                     w);
      logic [ROBID_W_MAX-1:0] mask;
      logic [ROBID_W_MAX-1:0] wrap_bits;
      logic                   gt;
      mask      = (32'd1 << (w - 1)) - 32'd1;
      wrap_bits = (a ^ b) >> (w - 1);
      gt        = (a & mask) > (b & mask);
      return wrap_bits[0] ^ gt;
   endfunction

endpackage

// File: rtl/exu_wb_chan_fifo.sv
// ---------------------------------------------------------------------------
// exu_wb_chan_fifo
// One writeback channel: DEPTH-entry ring buffer with per-entry valid (ev),
// flush-kill of younger entries in place, dead-entry drain at the head and an
// optional same-cycle bypass (EXU_WBPIPE_BYPASS_EN).
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   flush_valid, flush_robid  : squash everything younger than flush_robid
//   in_valid/in_ready         : push handshake; in_ready depends on state only
//   in_robid, in_payload      : pushed beat
//   out_valid/out_ready       : head handshake (dead heads never presented)
//   out_robid, out_payload    : head beat, zero when out_valid=0
//   occupancy                 : live + dead entries held
// ---------------------------------------------------------------------------
module exu_wb_chan_fifo
   import exu_wb_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int PAYLOAD_W = 128,
   parameter int ROBID_W   = ROBID_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   flush_valid,
   input  logic [ROBID_W-1:0]     flush_robid,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ROBID_W-1:0]     in_robid,
   input  logic [PAYLOAD_W-1:0]   in_payload,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ROBID_W-1:0]     out_robid,
   output logic [PAYLOAD_W-1:0]   out_payload,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ROBID_W-1:0]   robid_q   [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];
   logic [DEPTH-1:0]     ev_q;
   logic [PW-1:0]        rd_ptr_q;
   logic [PW-1:0]        wr_ptr_q;
   logic [CW-1:0]        count_q;

   logic [ROBID_W-1:0]   head_robid;
   logic                 not_empty;
   logic                 head_kill;
   logic                 in_kill;
   logic                 head_live;
   logic                 push;
   logic                 store;
   logic                 pop;
`ifdef EXU_WBPIPE_BYPASS_EN
   logic                 bypass;
`endif

   // NOTE: every signal written here gets a value before any branch, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      head_robid = robid_q[rd_ptr_q];
      not_empty  = count_q != '0;
      in_ready   = count_q != CW'(DEPTH);
      head_kill  = flush_valid & robid_younger(32'(head_robid), 32'(flush_robid), ROBID_W);
      in_kill    = flush_valid & robid_younger(32'(in_robid), 32'(flush_robid), ROBID_W);
      // A head being squashed this cycle is hidden; it drains next cycle.
      head_live  = not_empty & ev_q[rd_ptr_q] & ~head_kill;
      push       = in_valid & in_ready;
      // Dead heads leave one per cycle regardless of out_ready.
      pop        = not_empty & (~ev_q[rd_ptr_q] | (head_live & out_ready));
`ifdef EXU_WBPIPE_BYPASS_EN
      // Empty FIFO with a waiting consumer: hand the beat straight through.
      bypass      = ~not_empty & out_ready & in_valid & ~in_kill;
      store       = push & ~bypass;
      out_valid   = head_live | bypass;
      out_robid   = bypass ? in_robid   : (head_live ? head_robid          : '0);
      out_payload = bypass ? in_payload : (head_live ? payload_q[rd_ptr_q] : '0);
`else
      store       = push;
      out_valid   = head_live;
      out_robid   = head_live ? head_robid          : '0;
      out_payload = head_live ? payload_q[rd_ptr_q] : '0;
`endif
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ev_q     <= '0;
      end else begin
         if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
         if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
         count_q <= count_q + CW'(store) - CW'(pop);
         if (flush_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (robid_younger(32'(robid_q[i]), 32'(flush_robid), ROBID_W)) ev_q[i] <= 1'b0;
            end
         end
         if (pop)   ev_q[rd_ptr_q] <= 1'b0;
         // A beat killed on arrival still takes its slot, written dead.
         if (store) ev_q[wr_ptr_q] <= ~in_kill;
      end
   end

   // NOTE: entry storage has no reset; ev_q and count_q decide whether a slot
   // is ever looked at, so its contents after reset never matter.
   always_ff @(posedge clock) begin
      if (store) begin
         robid_q[wr_ptr_q]   <= in_robid;
         payload_q[wr_ptr_q] <= in_payload;
      end
   end

   assign occupancy = count_q;

endmodule

// File: rtl/exu_wb_pipereg.sv
// ---------------------------------------------------------------------------
// exu_wb_pipereg
// Multi-channel writeback pipeline register between execution units and the
// writeback/ROB-complete stage. Each channel is an independent exu_wb_chan_fifo;
// this level only slices the packed buses.
// Optional feature macro: EXU_WBPIPE_BYPASS_EN (0-cycle pass-through when a
// channel is empty and its consumer is ready).
// Ports (channel c at [c*W +: W] of each packed bus):
//   clock, reset_n                        : clock, async active-low reset
//   flush_valid, flush_robid              : squash entries younger than robid
//   in_valid, in_ready, in_robid, in_payload     : per-channel push side
//   out_valid, out_ready, out_robid, out_payload : per-channel head side
//   occupancy                             : per-channel entry count
// ---------------------------------------------------------------------------
module exu_wb_pipereg
   import exu_wb_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DEPTH     = 2,
   parameter int PAYLOAD_W = 128,
   parameter int ROBID_W   = ROBID_W_DEF
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                flush_valid,
   input  logic [ROBID_W-1:0]                  flush_robid,
   input  logic [NUM_CH-1:0]                   in_valid,
   output logic [NUM_CH-1:0]                   in_ready,
   input  logic [NUM_CH*ROBID_W-1:0]           in_robid,
   input  logic [NUM_CH*PAYLOAD_W-1:0]         in_payload,
   output logic [NUM_CH-1:0]                   out_valid,
   input  logic [NUM_CH-1:0]                   out_ready,
   output logic [NUM_CH*ROBID_W-1:0]           out_robid,
   output logic [NUM_CH*PAYLOAD_W-1:0]         out_payload,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] occupancy
);

   localparam int OW = $clog2(DEPTH) + 1;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      exu_wb_chan_fifo #(
         .DEPTH     (DEPTH),
         .PAYLOAD_W (PAYLOAD_W),
         .ROBID_W   (ROBID_W)
      ) u_fifo (
         .clock       (clock),
         .reset_n     (reset_n),
         .flush_valid (flush_valid),
         .flush_robid (flush_robid),
         .in_valid    (in_valid[c]),
         .in_ready    (in_ready[c]),
         .in_robid    (in_robid[c*ROBID_W +: ROBID_W]),
         .in_payload  (in_payload[c*PAYLOAD_W +: PAYLOAD_W]),
         .out_valid   (out_valid[c]),
         .out_ready   (out_ready[c]),
         .out_robid   (out_robid[c*ROBID_W +: ROBID_W]),
         .out_payload (out_payload[c*PAYLOAD_W +: PAYLOAD_W]),
         .occupancy   (occupancy[c*OW +: OW])
      );
   end

endmodule

// File: tb/tb_exu_wb_pipereg.sv
// ---------------------------------------------------------------------------
// tb_exu_wb_pipereg
// Self-checking bench for exu_wb_pipereg (NUM_CH=2, DEPTH=4, ROBID_W=5).
// A queue-per-channel reference model predicts every output each cycle; a
// vector table and hand sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_exu_wb_pipereg;

   localparam int NCH = 2;
   localparam int DEPTH = 4;
   localparam int PW = 16;
   localparam int RW = 5;
   localparam int OW = 3;
`ifdef EXU_WBPIPE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                clock;
   logic                reset_n;
   logic                flush_valid;
   logic [RW-1:0]       flush_robid;
   logic [NCH-1:0]      in_valid;
   logic [NCH-1:0]      in_ready;
   logic [NCH*RW-1:0]   in_robid;
   logic [NCH*PW-1:0]   in_payload;
   logic [NCH-1:0]      out_valid;
   logic [NCH-1:0]      out_ready;
   logic [NCH*RW-1:0]   out_robid;
   logic [NCH*PW-1:0]   out_payload;
   logic [NCH*OW-1:0]   occupancy;

   exu_wb_pipereg #(
      .NUM_CH(NCH), .DEPTH(DEPTH), .PAYLOAD_W(PW), .ROBID_W(RW)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .flush_valid(flush_valid), .flush_robid(flush_robid),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_robid(in_robid), .in_payload(in_payload),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_robid(out_robid), .out_payload(out_payload),
      .occupancy(occupancy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [RW-1:0] robid;
      logic [PW-1:0] pay;
      logic          alive;
   } ent_t;

   ent_t mq [NCH][$];
   bit   m_ov  [NCH];
   bit   m_byp [NCH];
   bit   m_ir  [NCH];

   int total = 0;
   int passed = 0;
   int cyc = 0;

   function automatic bit young(input logic [RW-1:0] a, input logic [RW-1:0] b);
      int ah, bh, al, bl;
      ah = int'(a) / 16;  bh = int'(b) / 16;
      al = int'(a) % 16;  bl = int'(b) % 16;
      return (ah != bh) != (al > bl);
   endfunction

   function automatic logic [PW-1:0] pay_of(input int c, input logic [RW-1:0] r);
      return 16'(c * 4096) ^ {r, 6'(r), r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
   endtask

   // Apply one cycle of inputs, then compare every output with the model.
   task automatic drive(input logic [1:0] iv, input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                        input logic [1:0] ordy, input logic fv, input logic [RW-1:0] fr);
      ent_t          h;
      int            sz;
      bit            hk, hl, ik;
      logic [RW-1:0] er;
      logic [PW-1:0] ep;
      logic [RW-1:0] rin;
      in_valid    = iv;
      in_robid    = {r1, r0};
      in_payload  = {pay_of(1, r1), pay_of(0, r0)};
      out_ready   = ordy;
      flush_valid = fv;
      flush_robid = fr;
      #2;
      for (int c = 0; c < NCH; c++) begin
         rin = (c == 0) ? r0 : r1;
         sz  = mq[c].size();
         h   = (sz > 0) ? mq[c][0] : '0;
         m_ir[c]  = (sz != DEPTH);
         hl       = (sz > 0) && h.alive;
         hk       = (sz > 0) && fv && young(h.robid, fr);
         ik       = fv && young(rin, fr);
         m_byp[c] = BYP && (sz == 0) && ordy[c] && iv[c] && !ik;
         m_ov[c]  = (hl && !hk) || m_byp[c];
         er = m_byp[c] ? rin : (m_ov[c] ? h.robid : '0);
         ep = m_byp[c] ? pay_of(c, rin) : (m_ov[c] ? h.pay : '0);
         check($sformatf("in_ready ch%0d", c),    32'(in_ready[c]),          32'(m_ir[c]));
         check($sformatf("out_valid ch%0d", c),   32'(out_valid[c]),         32'(m_ov[c]));
         check($sformatf("out_robid ch%0d", c),   32'(out_robid[c*RW +: RW]), 32'(er));
         check($sformatf("out_payload ch%0d", c), 32'(out_payload[c*PW +: PW]), 32'(ep));
         check($sformatf("occupancy ch%0d", c),   32'(occupancy[c*OW +: OW]), sz);
      end
   endtask

   // Clock edge: advance the model with the inputs still held.
   task automatic advance();
      ent_t          e;
      logic [RW-1:0] rin;
      @(posedge clock);
      for (int c = 0; c < NCH; c++) begin
         rin = in_robid[c*RW +: RW];
         if (mq[c].size() > 0 && (!mq[c][0].alive || (m_ov[c] && !m_byp[c] && out_ready[c])))
            void'(mq[c].pop_front());
         if (flush_valid) begin
            for (int i = 0; i < mq[c].size(); i++) begin
               e = mq[c][i];
               if (young(e.robid, flush_robid)) begin
                  e.alive = 1'b0;
                  mq[c][i] = e;
               end
            end
         end
         if (in_valid[c] && m_ir[c] && !m_byp[c]) begin
            e.robid = rin;
            e.pay   = pay_of(c, rin);
            e.alive = !(flush_valid && young(rin, flush_robid));
            mq[c].push_back(e);
         end
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic idle(input logic [1:0] ordy);
      drive(2'b00, '0, '0, ordy, 1'b0, '0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      in_valid = '0; in_robid = '0; in_payload = '0;
      out_ready = '0; flush_valid = 1'b0; flush_robid = '0;
      for (int c = 0; c < NCH; c++) mq[c].delete();
      #2;
      check("reset in_ready",    32'(in_ready),    32'h3);
      check("reset out_valid",   32'(out_valid),   32'h0);
      check("reset out_robid",   32'(out_robid),   32'h0);
      check("reset out_payload", 32'(out_payload), 32'h0);
      check("reset occupancy",   32'(occupancy),   32'h0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0]    iv;
      logic [RW-1:0] r0;
      logic [RW-1:0] r1;
      logic [1:0]    ordy;
      logic [1:0]    exp_ov;
      logic [1:0]    exp_ir;
      int            exp_occ0;
      int            exp_occ1;
      logic [RW-1:0] exp_or0;
      logic [RW-1:0] exp_or1;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      in_valid = '0; in_robid = '0; in_payload = '0;
      out_ready = '0; flush_valid = 1'b0; flush_robid = '0;

      // Expected values are those seen before the clock edge of each row.
      tbl[0]  = '{2'b01, 5'd5, 5'd0, 2'b00, 2'b00, 2'b11, 0, 0, 5'd0, 5'd0};
      tbl[1]  = '{2'b00, 5'd0, 5'd0, 2'b00, 2'b01, 2'b11, 1, 0, 5'd5, 5'd0};
      tbl[2]  = '{2'b00, 5'd0, 5'd0, 2'b01, 2'b01, 2'b11, 1, 0, 5'd5, 5'd0};
      tbl[3]  = '{2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 2'b11, 0, 0, 5'd0, 5'd0};
      tbl[4]  = '{2'b10, 5'd0, 5'd3, 2'b00, 2'b00, 2'b11, 0, 0, 5'd0, 5'd0};
      tbl[5]  = '{2'b10, 5'd0, 5'd4, 2'b00, 2'b10, 2'b11, 0, 1, 5'd0, 5'd3};
      tbl[6]  = '{2'b10, 5'd0, 5'd5, 2'b00, 2'b10, 2'b11, 0, 2, 5'd0, 5'd3};
      tbl[7]  = '{2'b10, 5'd0, 5'd6, 2'b00, 2'b10, 2'b11, 0, 3, 5'd0, 5'd3};
      tbl[8]  = '{2'b10, 5'd0, 5'd7, 2'b00, 2'b10, 2'b01, 0, 4, 5'd0, 5'd3};
      tbl[9]  = '{2'b10, 5'd0, 5'd7, 2'b10, 2'b10, 2'b01, 0, 4, 5'd0, 5'd3};
      tbl[10] = '{2'b10, 5'd0, 5'd7, 2'b10, 2'b10, 2'b11, 0, 3, 5'd0, 5'd4};
      tbl[11] = '{2'b00, 5'd0, 5'd0, 2'b00, 2'b10, 2'b11, 0, 3, 5'd0, 5'd5};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].iv, tbl[i].r0, tbl[i].r1, tbl[i].ordy, 1'b0, '0);
         check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
         check($sformatf("tbl%0d in_ready", i),  32'(in_ready),  32'(tbl[i].exp_ir));
         check($sformatf("tbl%0d occ0", i),      32'(occupancy[0 +: OW]),  tbl[i].exp_occ0);
         check($sformatf("tbl%0d occ1", i),      32'(occupancy[OW +: OW]), tbl[i].exp_occ1);
         check($sformatf("tbl%0d robid0", i),    32'(out_robid[0 +: RW]),  32'(tbl[i].exp_or0));
         check($sformatf("tbl%0d robid1", i),    32'(out_robid[RW +: RW]), 32'(tbl[i].exp_or1));
         advance();
      end

      // Flush 7 over stored 7,9,8: 9 and 8 die behind the head and drain.
      do_reset();
      drive(2'b01, 5'd7, '0, 2'b00, 1'b0, '0); advance();
      drive(2'b01, 5'd9, '0, 2'b00, 1'b0, '0); advance();
      drive(2'b01, 5'd8, '0, 2'b00, 1'b0, '0); advance();
      drive(2'b00, '0, '0, 2'b00, 1'b1, 5'd7);
      check("flush head kept valid", 32'(out_valid[0]), 32'h1);
      check("flush head robid",      32'(out_robid[0 +: RW]), 32'd7);
      advance();
      idle(2'b01);
      check("flush pop 7", 32'(out_robid[0 +: RW]), 32'd7);
      advance();
      idle(2'b01);
      check("drain1 out_valid", 32'(out_valid[0]), 32'h0);
      check("drain1 occ0",      32'(occupancy[0 +: OW]), 32'd2);
      advance();
      idle(2'b01);
      check("drain2 out_valid", 32'(out_valid[0]), 32'h0);
      check("drain2 occ0",      32'(occupancy[0 +: OW]), 32'd1);
      advance();
      idle(2'b01);
      check("drained occ0", 32'(occupancy[0 +: OW]), 32'd0);
      advance();

      // Wrap-bit compare: flush 0b0_1110 kills 0b1_0001, keeps 13 and 14.
      do_reset();
      drive(2'b01, 5'd13, '0, 2'b00, 1'b0, '0); advance();
      drive(2'b01, 5'b1_0001, '0, 2'b00, 1'b0, '0); advance();
      drive(2'b01, 5'd14, '0, 2'b00, 1'b0, '0); advance();
      drive(2'b00, '0, '0, 2'b00, 1'b1, 5'b0_1110);
      check("wrap head 13 valid", 32'(out_valid[0]), 32'h1);
      advance();
      idle(2'b01); advance();
      idle(2'b01);
      check("wrap 17 killed", 32'(out_valid[0]), 32'h0);
      advance();
      idle(2'b01);
      check("wrap equal kept", 32'(out_robid[0 +: RW]), 32'd14);
      advance();
      idle(2'b00); advance();

      // Killed beat on an empty channel still handshakes but never shows.
      do_reset();
      drive(2'b01, 5'd10, '0, 2'b01, 1'b1, 5'd6);
      check("killed push in_ready",  32'(in_ready[0]),  32'h1);
      check("killed push out_valid", 32'(out_valid[0]), 32'h0);
      advance();
      idle(2'b01);
      check("killed entry occ0", 32'(occupancy[0 +: OW]), 32'd1);
      check("killed entry hidden", 32'(out_valid[0]), 32'h0);
      advance();
      idle(2'b01); advance();
      drive(2'b01, 5'd4, '0, 2'b01, 1'b1, 5'd6);
      check("survivor same-cycle valid", 32'(out_valid[0]), BYP ? 32'h1 : 32'h0);
      advance();
      idle(2'b01);
      check("survivor next-cycle valid", 32'(out_valid[0]), BYP ? 32'h0 : 32'h1);
      advance();
      idle(2'b00); advance();

      // Asynchronous reset with entries stored.
      do_reset();
      drive(2'b11, 5'd1, 5'd2, 2'b00, 1'b0, '0); advance();
      drive(2'b01, 5'd3, '0, 2'b00, 1'b0, '0); advance();
      idle(2'b00);
      check("pre-reset occ0", 32'(occupancy[0 +: OW]), 32'd2);
      reset_n = 1'b0;
      #1;
      check("async out_valid", 32'(out_valid),   32'h0);
      check("async in_ready",  32'(in_ready),    32'h3);
      check("async occupancy", 32'(occupancy),   32'h0);
      check("async robid",     32'(out_robid),   32'h0);
      check("async payload",   32'(out_payload), 32'h0);
      for (int c = 0; c < NCH; c++) mq[c].delete();
      @(negedge clock);
      reset_n = 1'b1;

      // Randomized traffic against the model.
      for (int n = 0; n < 500; n++) begin
         drive(2'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
               ($urandom_range(5) == 0), 5'($urandom));
         advance();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
